tt_lut_seq: RTL and testbench

//  Programmable N-input truth-table evaluator: the parametrised successor to fixed case-table gates.
//  The 2^NIN-entry table loads at run time over a chunked valid/ready config port.

---
 rtl/tt_lut_seq_if.sv | 28 ++
 rtl/tt_lut_seq.sv | 76 +++++++
 tb/tb_tt_lut_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_lut_seq_if.sv
// tt_lut_seq_if: config and evaluate handshakes of the truth-table evaluator
interface tt_lut_seq_if #(
    parameter int NIN   = 3,
    parameter int CHUNK = 4
);
    logic             cfg_start;
    logic             cfg_valid;
    logic [CHUNK-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_done;
    logic             tt_loaded;
    logic             in_valid;
    logic [NIN-1:0]   in_bits;
    logic             in_ready;
    logic             out_valid;
    logic             out;
    logic             out_ready;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_bits, out_ready,
        input  cfg_ready, cfg_done, tt_loaded, in_ready, out_valid, out
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_bits, out_ready,
        output cfg_ready, cfg_done, tt_loaded, in_ready, out_valid, out
    );
endinterface

// File: rtl/tt_lut_seq.sv
// tt_lut_seq: run-time loadable NIN-input truth table with a 1-cycle valid/ready evaluate pipe
module tt_lut_seq #(
    parameter int NIN   = 3,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    tt_lut_seq_if.slave  bus
);
    localparam int TW = 1 << NIN;
    localparam int NB = TW / CHUNK;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, idx;
    logic [TW-1:0]   tt;
    logic            beat, last, accept;

    assign bus.cfg_ready = state == LOAD;
    assign bus.in_ready  = (state == RUN) & ~bus.cfg_start & (~bus.out_valid | bus.out_ready);

    // Beat bookkeeping and next state; a cfg_start arriving with a beat makes it beat 0
    always_comb begin
        idx       = bus.cfg_start ? '0 : cnt;
        beat      = (state == LOAD) & bus.cfg_valid;
        last      = beat & (idx == CW'(NB - 1));
        accept    = bus.in_valid & bus.in_ready;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.cfg_start ? LOAD : IDLE;
            LOAD:    state_nxt = last ? RUN : LOAD;
            RUN:     state_nxt = bus.cfg_start ? LOAD : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Table load: write chunks, count beats, flag completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt            <= '0;
            cnt           <= '0;
            bus.cfg_done  <= 1'b0;
            bus.tt_loaded <= 1'b0;
        end else begin
            bus.cfg_done  <= last;
            bus.tt_loaded <= last | (bus.tt_loaded & ~bus.cfg_start);
            if (beat) begin
                tt[idx*CHUNK +: CHUNK] <= bus.cfg_data;
                cnt                    <= last ? '0 : idx + 1'b1;
            end else if (bus.cfg_start) begin
                cnt <= '0;
            end
        end
    end

    // Result register: load on accept, drop valid once consumed, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out       <= tt[bus.in_bits];
            bus.out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tt_lut_seq.sv
// tb_tt_lut_seq: randomized scenario bench for tt_lut_seq against a table/queue reference model
module tb_tt_lut_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vecs = 0;
    int errs = 0;
    logic [3:0] ref_a;
    logic [7:0] ref_b;
    logic       run_a;

    always #5 clk = ~clk;

    tt_lut_seq_if #(.NIN(2), .CHUNK(2)) ia ();
    tt_lut_seq_if #(.NIN(3), .CHUNK(8)) ib ();

    tt_lut_seq #(.NIN(2), .CHUNK(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    tt_lut_seq #(.NIN(3), .CHUNK(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beats_a(input logic [3:0] t);
        for (int k = 0; k < 2; k++) begin
            ia.cfg_valid = 1'b1;
            ia.cfg_data  = t[k*2 +: 2];
            step();
        end
        ia.cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        {ia.cfg_start, ia.cfg_valid, ia.cfg_data, ia.in_bits} = '0;
        {ib.cfg_start, ib.cfg_valid, ib.cfg_data, ib.in_bits} = '0;
        ia.in_valid = 1'b1; ib.in_valid = 1'b1;
        ia.out_ready = 1'b1; ib.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        vecs++;
        if ({ia.cfg_ready, ia.cfg_done, ia.tt_loaded, ia.in_ready, ia.out_valid, ia.out} !== 6'b0) begin
            errs++;
            $display("FAIL reset_a: got %b want 000000", {ia.cfg_ready, ia.cfg_done, ia.tt_loaded, ia.in_ready, ia.out_valid, ia.out});
        end
        vecs++;
        if ({ib.cfg_ready, ib.cfg_done, ib.tt_loaded, ib.in_ready, ib.out_valid, ib.out} !== 6'b0) begin
            errs++;
            $display("FAIL reset_b: got %b want 000000", {ib.cfg_ready, ib.cfg_done, ib.tt_loaded, ib.in_ready, ib.out_valid, ib.out});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vecs++;
            if ({ia.in_ready, ia.out_valid, ia.cfg_ready} !== 3'b0) begin
                errs++;
                $display("FAIL idle_ignore: got %b want 000", {ia.in_ready, ia.out_valid, ia.cfg_ready});
            end
        end
        ia.in_valid = 1'b0; ib.in_valid = 1'b0;
        ref_a = '0; ref_b = '0; run_a = 1'b0;
    endtask

    task automatic test_load_a(input logic [3:0] t);
        ia.cfg_start = 1'b1;
        step();
        ia.cfg_start = 1'b0;
        vecs++;
        if ({ia.tt_loaded, ia.cfg_ready} !== 2'b01) begin
            errs++;
            $display("FAIL load_enter: got %b want 01", {ia.tt_loaded, ia.cfg_ready});
        end
        beats_a(t);
        vecs++;
        if ({ia.cfg_done, ia.tt_loaded, ia.cfg_ready} !== 3'b110) begin
            errs++;
            $display("FAIL load_done: got %b want 110", {ia.cfg_done, ia.tt_loaded, ia.cfg_ready});
        end
        step();
        vecs++;
        if ({ia.cfg_done, ia.tt_loaded} !== 2'b01) begin
            errs++;
            $display("FAIL done_pulse: got %b want 01", {ia.cfg_done, ia.tt_loaded});
        end
        ref_a = t;
        run_a = 1'b1;
    endtask

    task automatic test_xnor;
        test_load_a(4'b1001);
        ia.out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            ia.in_valid = 1'b1;
            ia.in_bits  = 2'(v);
            #1;
            vecs++;
            if (ia.in_ready !== 1'b1) begin
                errs++;
                $display("FAIL xnor_ready[%0d]: got %b want 1", v, ia.in_ready);
            end
            @(posedge clk);
            #1;
            vecs++;
            if (ia.out_valid !== 1'b1 || ia.out !== ref_a[v]) begin
                errs++;
                $display("FAIL xnor_out[%0d]: got v=%b o=%b want v=1 o=%b", v, ia.out_valid, ia.out, ref_a[v]);
            end
        end
        ia.in_valid = 1'b0;
        step();
        vecs++;
        if (ia.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL xnor_drain: got %b want 0", ia.out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic q[$];
        logic exp_rdy;
        for (int c = 0; c < 70; c++) begin
            ia.in_valid  = c < 60 ? 1'($urandom_range(0, 1)) : 1'b0;
            ia.in_bits   = 2'($urandom);
            ia.out_ready = c < 50 ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            exp_rdy = run_a & (q.size() == 0 || ia.out_ready);
            vecs++;
            if (ia.in_ready !== exp_rdy) begin
                errs++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, ia.in_ready, exp_rdy);
            end
            if (q.size() != 0 && ia.out_ready) void'(q.pop_front());
            if (ia.in_valid && exp_rdy) q.push_back(ref_a[ia.in_bits]);
            @(posedge clk);
            #1;
            vecs++;
            if (ia.out_valid !== (q.size() != 0) || (q.size() != 0 && ia.out !== q[0])) begin
                errs++;
                $display("FAIL bp_out[%0d]: got v=%b o=%b want v=%0d o=%b", c, ia.out_valid, ia.out, q.size() != 0, q.size() != 0 ? q[0] : 1'b0);
            end
        end
        ia.in_valid = 1'b0;
    endtask

    task automatic test_reload;
        int vl[2] = '{3, 1};
        logic pend;
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        ia.in_bits   = 2'b00;
        pend = ref_a[0];
        step();
        ia.cfg_start = 1'b1;
        ia.in_bits   = 2'b11;
        #1;
        vecs++;
        if (ia.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL reload_ready: got %b want 0", ia.in_ready);
        end
        @(posedge clk);
        #1;
        vecs++;
        if ({ia.out_valid, ia.out, ia.tt_loaded} !== {1'b1, pend, 1'b0}) begin
            errs++;
            $display("FAIL reload_pending: got %b want %b", {ia.out_valid, ia.out, ia.tt_loaded}, {1'b1, pend, 1'b0});
        end
        ia.cfg_start = 1'b0;
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        step();
        vecs++;
        if ({ia.out_valid, ia.out} !== {1'b0, pend}) begin
            errs++;
            $display("FAIL reload_consume: got %b want %b", {ia.out_valid, ia.out}, {1'b0, pend});
        end
        beats_a(4'b1000);
        ref_a = 4'b1000;
        vecs++;
        if ({ia.cfg_done, ia.tt_loaded} !== 2'b11) begin
            errs++;
            $display("FAIL reload_done: got %b want 11", {ia.cfg_done, ia.tt_loaded});
        end
        for (int i = 0; i < 2; i++) begin
            ia.in_valid = 1'b1;
            ia.in_bits  = 2'(vl[i]);
            @(posedge clk);
            #1;
            vecs++;
            if (ia.out_valid !== 1'b1 || ia.out !== ref_a[vl[i]]) begin
                errs++;
                $display("FAIL and_out[%0d]: got v=%b o=%b want v=1 o=%b", vl[i], ia.out_valid, ia.out, ref_a[vl[i]]);
            end
        end
        ia.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_load;
        logic [3:0] t;
        ia.cfg_start = 1'b1;
        step();
        ia.cfg_start = 1'b0;
        ia.cfg_valid = 1'b1;
        ia.cfg_data  = 2'b11;
        step();
        ia.cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({ia.tt_loaded, ia.cfg_ready, ia.in_ready, ia.cfg_done, dut_a.tt} !== 8'b0) begin
            errs++;
            $display("FAIL midload_reset: got %b want 00000000", {ia.tt_loaded, ia.cfg_ready, ia.in_ready, ia.cfg_done, dut_a.tt});
        end
        step();
        rst_n = 1'b1;
        run_a = 1'b0;
        ref_a = '0;
        step();
        t = 4'($urandom);
        test_load_a(t);
        for (int v = 0; v < 4; v++) begin
            ia.in_valid = 1'b1;
            ia.in_bits  = 2'(v);
            @(posedge clk);
            #1;
            vecs++;
            if (ia.out_valid !== 1'b1 || ia.out !== ref_a[v]) begin
                errs++;
                $display("FAIL fresh_out[%0d]: got v=%b o=%b want v=1 o=%b", v, ia.out_valid, ia.out, ref_a[v]);
            end
        end
        ia.in_valid = 1'b0;
        step();
    endtask

    task automatic test_single_beat;
        int vl[3] = '{5, 7, 1};
        logic [7:0] t;
        logic [2:0] b;
        ib.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            t = r == 0 ? 8'b1010_0000 : 8'($urandom);
            ib.cfg_start = 1'b1;
            step();
            ib.cfg_start = 1'b0;
            ib.cfg_valid = 1'b1;
            ib.cfg_data  = t;
            step();
            ib.cfg_valid = 1'b0;
            ref_b = t;
            vecs++;
            if ({ib.cfg_done, ib.tt_loaded} !== 2'b11) begin
                errs++;
                $display("FAIL nb1_done[%0d]: got %b want 11", r, {ib.cfg_done, ib.tt_loaded});
            end
            step();
            vecs++;
            if (ib.cfg_done !== 1'b0) begin
                errs++;
                $display("FAIL nb1_pulse[%0d]: got %b want 0", r, ib.cfg_done);
            end
            for (int i = 0; i < (r == 0 ? 3 : 16); i++) begin
                b = r == 0 ? 3'(vl[i]) : 3'($urandom);
                ib.in_valid = 1'b1;
                ib.in_bits  = b;
                @(posedge clk);
                #1;
                vecs++;
                if (ib.out_valid !== 1'b1 || ib.out !== ref_b[b]) begin
                    errs++;
                    $display("FAIL nb1_out[%0d]: got v=%b o=%b want v=1 o=%b", b, ib.out_valid, ib.out, ref_b[b]);
                end
            end
            ib.in_valid = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_xnor();
        test_backpressure();
        test_reload();
        test_reset_mid_load();
        test_single_beat();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
